hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Observes the decoded instruction fields of the instruction in ID and keeps its own shadow copy of destination registers in flight in EX, MEM and WB.
- Drives PC/IF-ID stall, IF-ID flush and EX bubble insertion; optionally registers operand-forwarding selects for the EX stage.
- Sits beside the ID stage and sequences the register-file read path against in-flight writes.

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).
//
// Keeps a shadow copy of the destination registers in flight in EX, MEM and WB.
// It compares them against the sources of the instruction in ID and drives the
// stall, flush and bubble controls. It also keeps a saturating stall-cycle counter.
//
// Build option:
//   HAZARD_FORWARD_EN  defined   -> only load-use (EX) and WB matches stall. Other
//                                   matches are forwarded, and fwd_a/fwd_b are
//                                   registered as the instruction enters EX.
//                      undefined -> any EX/MEM/WB match stalls. fwd_a/fwd_b stay 00.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   id_valid           ID holds a real instruction
//   opcode_id, rs1_id, rs2_id, rd_id   decoded fields of the ID instruction
//   branch_taken_ex    branch/jump in EX resolved taken
//   stall_id           hold PC and IF/ID (combinational)
//   flush_id           load NOP into IF/ID (combinational)
//   bubble_ex          load NOP into ID/EX (combinational)
//   fwd_a, fwd_b       EX operand source selects (registered; 10=MEM, 01=WB, 00=RF)
//   stall_count        saturating count of stall cycles
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       opcode_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             branch_taken_ex,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic uses_rs1, uses_rs2, writes_rd, is_load;

  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_wr, mem_wr, wb_wr;

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic hazard;

  // Decode of the ID instruction
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = (opcode_id == OP_LOAD);
    case (opcode_id)
      OP_REG:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_JAL:    writes_rd = 1'b1;
      OP_LUI:    writes_rd = 1'b1;
      OP_AUIPC:  writes_rd = 1'b1;
      default:   ;
    endcase
    // x0 is never a real destination, so it can never produce a match
    if (rd_id == 5'd0) writes_rd = 1'b0;
  end

  // Source/destination matches per stage
  always_comb begin
    ex_m1  = id_valid & uses_rs1 & ex_wr  & (ex_rd  == rs1_id);
    ex_m2  = id_valid & uses_rs2 & ex_wr  & (ex_rd  == rs2_id);
    mem_m1 = id_valid & uses_rs1 & mem_wr & (mem_rd == rs1_id);
    mem_m2 = id_valid & uses_rs2 & mem_wr & (mem_rd == rs2_id);
    wb_m1  = id_valid & uses_rs1 & wb_wr  & (wb_rd  == rs1_id);
    wb_m2  = id_valid & uses_rs2 & wb_wr  & (wb_rd  == rs2_id);
  end

`ifdef HAZARD_FORWARD_EN
  logic ex_ld;

  // A load's data appears only after MEM, so an EX load match must wait.
  // The WB value is written on the same edge it would be read, so it also waits.
  assign hazard = ((ex_m1 | ex_m2) & ex_ld) | wb_m1 | wb_m2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld <= 1'b0;
    end else if (bubble_ex || !id_valid) begin
      ex_ld <= 1'b0;
    end else begin
      ex_ld <= is_load;
    end
  end

  // Selects are captured as the instruction moves into EX. The EX producer
  // will sit in MEM next cycle (10); the MEM producer will sit in WB (01).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (bubble_ex) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else begin
      fwd_a <= (ex_m1 & ~ex_ld) ? 2'b10 : (mem_m1 ? 2'b01 : 2'b00);
      fwd_b <= (ex_m2 & ~ex_ld) ? 2'b10 : (mem_m2 ? 2'b01 : 2'b00);
    end
  end
`else
  assign hazard = ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2;
  assign fwd_a  = '0;
  assign fwd_b  = '0;
`endif

  // A taken branch must let the PC load its target, so it overrides the stall
  always_comb begin
    stall_id  = hazard & ~branch_taken_ex;
    bubble_ex = hazard | branch_taken_ex;
    flush_id  = branch_taken_ex;
  end

  // Shadow pipeline of destinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0;
      ex_wr  <= 1'b0;
      mem_rd <= '0;
      mem_wr <= 1'b0;
      wb_rd  <= '0;
      wb_wr  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      if (bubble_ex || !id_valid) begin
        ex_rd <= '0;
        ex_wr <= 1'b0;
      end else begin
        ex_rd <= rd_id;
        ex_wr <= writes_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_id && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 2;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [6:0]       opcode_id;
  logic [4:0]       rs1_id, rs2_id, rd_id;
  logic             branch_taken_ex;
  logic             stall_id, flush_id, bubble_ex;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .opcode_id       (opcode_id),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rd_id           (rd_id),
    .branch_taken_ex (branch_taken_ex),
    .stall_id        (stall_id),
    .flush_id        (flush_id),
    .bubble_ex       (bubble_ex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_count     (stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setid(input logic v, input logic [6:0] op,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    id_valid  = v;
    opcode_id = op;
    rs1_id    = a;
    rs2_id    = b;
    rd_id     = d;
  endtask

  task automatic idle;
    setid(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle;
    branch_taken_ex = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_stall", 16'(stall_id), 16'd0);
    chk("rst_bubble", 16'(bubble_ex), 16'd0);
    chk("rst_flush", 16'(flush_id), 16'd0);
    chk("rst_fwd_a", 16'(fwd_a), 16'd0);
    chk("rst_fwd_b", 16'(fwd_b), 16'd0);
    chk("rst_count", 16'(stall_count), 16'd0);
    rst_n = 1'b1;
    step;

    // addi x0,x0,1 ; add x8,x0,x0 : x0 never creates a dependency
    setid(1'b1, OP_I, 5'd0, 5'd0, 5'd0); #1;
    chk("x0_prod_stall", 16'(stall_id), 16'd0);
    step;
    setid(1'b1, OP_R, 5'd0, 5'd0, 5'd8); #1;
    chk("x0_cons_stall", 16'(stall_id), 16'd0);
    chk("x0_cons_bubble", 16'(bubble_ex), 16'd0);
    step;
    idle;
    do_reset;

    // add x1,x2,x3 ; add x4,x1,x5 back-to-back
    setid(1'b1, OP_R, 5'd2, 5'd3, 5'd1); #1;
    chk("b2b_prod_stall", 16'(stall_id), 16'd0);
    step;
    setid(1'b1, OP_R, 5'd1, 5'd5, 5'd4); #1;
`ifdef HAZARD_FORWARD_EN
    chk("b2b_fwd_stall", 16'(stall_id), 16'd0);
    chk("b2b_fwd_bubble", 16'(bubble_ex), 16'd0);
    step;
    chk("b2b_fwd_a", 16'(fwd_a), 16'd2);
    chk("b2b_fwd_b", 16'(fwd_b), 16'd0);
    chk("b2b_fwd_count", 16'(stall_count), 16'd0);
`else
    chk("b2b_ex_stall", 16'(stall_id), 16'd1);
    chk("b2b_ex_bubble", 16'(bubble_ex), 16'd1);
    chk("b2b_ex_flush", 16'(flush_id), 16'd0);
    step;
    chk("b2b_mem_stall", 16'(stall_id), 16'd1);
    chk("b2b_mem_count", 16'(stall_count), 16'd1);
    step;
    chk("b2b_wb_stall", 16'(stall_id), 16'd1);
    chk("b2b_wb_count", 16'(stall_count), 16'd2);
    step;
    chk("b2b_issue_stall", 16'(stall_id), 16'd0);
    chk("b2b_issue_bubble", 16'(bubble_ex), 16'd0);
    chk("b2b_count", 16'(stall_count), 16'd3);
    step;
    chk("b2b_fwd_a_off", 16'(fwd_a), 16'd0);
`endif
    idle;
    do_reset;

    // add x1 ; nop ; add x4,x1,x5
    setid(1'b1, OP_R, 5'd2, 5'd3, 5'd1); #1;
    step;
    idle;
    step;
    setid(1'b1, OP_R, 5'd1, 5'd5, 5'd4); #1;
`ifdef HAZARD_FORWARD_EN
    chk("gap1_fwd_stall", 16'(stall_id), 16'd0);
    step;
    chk("gap1_fwd_a", 16'(fwd_a), 16'd1);
    chk("gap1_fwd_b", 16'(fwd_b), 16'd0);
`else
    chk("gap1_mem_stall", 16'(stall_id), 16'd1);
    step;
    chk("gap1_wb_stall", 16'(stall_id), 16'd1);
    step;
    chk("gap1_issue_stall", 16'(stall_id), 16'd0);
    chk("gap1_count", 16'(stall_count), 16'd2);
    step;
`endif
    idle;
    step;
    chk("gap1_idle_fwd_a", 16'(fwd_a), 16'd0);
    do_reset;

    // lw x5,0(x6) ; add x7,x5,x0
    setid(1'b1, OP_LOAD, 5'd6, 5'd0, 5'd5); #1;
    step;
    setid(1'b1, OP_R, 5'd5, 5'd0, 5'd7); #1;
    chk("lu_ex_stall", 16'(stall_id), 16'd1);
    chk("lu_ex_bubble", 16'(bubble_ex), 16'd1);
    step;
`ifdef HAZARD_FORWARD_EN
    chk("lu_fwd_issue_stall", 16'(stall_id), 16'd0);
    step;
    chk("lu_fwd_a", 16'(fwd_a), 16'd1);
    chk("lu_fwd_b", 16'(fwd_b), 16'd0);
    chk("lu_fwd_count", 16'(stall_count), 16'd1);
`else
    chk("lu_mem_stall", 16'(stall_id), 16'd1);
    step;
    chk("lu_wb_stall", 16'(stall_id), 16'd1);
    step;
    chk("lu_issue_stall", 16'(stall_id), 16'd0);
    chk("lu_count", 16'(stall_count), 16'd3);
`endif
    idle;
    do_reset;

    // lw x5 ; nop ; nop ; add x7,x5,x0 : one stall for the WB write in both builds
    setid(1'b1, OP_LOAD, 5'd6, 5'd0, 5'd5); #1;
    step;
    idle;
    step;
    step;
    setid(1'b1, OP_R, 5'd5, 5'd0, 5'd7); #1;
    chk("gap2_wb_stall", 16'(stall_id), 16'd1);
    chk("gap2_wb_bubble", 16'(bubble_ex), 16'd1);
    step;
    chk("gap2_issue_stall", 16'(stall_id), 16'd0);
    chk("gap2_count", 16'(stall_count), 16'd1);
    step;
    chk("gap2_fwd_a", 16'(fwd_a), 16'd0);

    // Load-use coinciding with a taken branch: branch wins, counter holds at 1
    setid(1'b1, OP_LOAD, 5'd6, 5'd0, 5'd5); #1;
    step;
    setid(1'b1, OP_R, 5'd5, 5'd0, 5'd7);
    branch_taken_ex = 1'b1; #1;
    chk("br_stall", 16'(stall_id), 16'd0);
    chk("br_flush", 16'(flush_id), 16'd1);
    chk("br_bubble", 16'(bubble_ex), 16'd1);
    step;
    chk("br_count", 16'(stall_count), 16'd1);
    branch_taken_ex = 1'b0;
    idle;
    #1;
    chk("br_release_flush", 16'(flush_id), 16'd0);
    do_reset;

    // Five single-cycle WB stalls: counter saturates at 3 without wrapping
    for (int unsigned i = 0; i < 5; i++) begin
      setid(1'b1, OP_R, 5'd2, 5'd3, 5'd1);
      step;
      idle;
      step;
      step;
      setid(1'b1, OP_R, 5'd1, 5'd0, 5'd4); #1;
      chk("sat_stall", 16'(stall_id), 16'd1);
      step;
      chk("sat_issue", 16'(stall_id), 16'd0);
      chk("sat_count", 16'(stall_count), 16'((i + 1 > 3) ? 3 : i + 1));
      idle;
    end

    // Reset asserted in the middle of a stall
    setid(1'b1, OP_R, 5'd2, 5'd3, 5'd1);
    step;
    idle;
    step;
    step;
    setid(1'b1, OP_R, 5'd1, 5'd0, 5'd4); #1;
    chk("mid_pre_stall", 16'(stall_id), 16'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_count", 16'(stall_count), 16'd0);
    chk("mid_rst_stall", 16'(stall_id), 16'd0);
    chk("mid_rst_bubble", 16'(bubble_ex), 16'd0);
    chk("mid_rst_fwd_a", 16'(fwd_a), 16'd0);
    chk("mid_rst_fwd_b", 16'(fwd_b), 16'd0);
    rst_n = 1'b1;
    setid(1'b1, OP_R, 5'd10, 5'd11, 5'd12); #1;
    chk("mid_indep_stall", 16'(stall_id), 16'd0);
    step;
    chk("mid_indep_count", 16'(stall_count), 16'd0);
    idle;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
